// File: rtl/contador_updown_modulo.sv
// Up/down modulo counter with programmable modulus, synchronous load, prescaled
// count enable, wrap/saturate selection, terminal-count and event flags.
module contador_updown_modulo #(
    parameter int width       = 4,
    parameter int max_count   = 2**width-1,
    parameter int reset_value = max_count,
    parameter bit saturate    = 1'b0,
    parameter int prescale    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [width-1:0] d,
    output logic [width-1:0] q,
    output logic             tc,
    output logic             evt
);

    localparam logic [width:0]   max_ext = (width+1)'(max_count);
    localparam logic [width:0]   one_ext = (width+1)'(1);
    localparam logic [width-1:0] max_q   = width'(max_count);
    localparam logic [width-1:0] rst_q   = width'(reset_value);
    localparam logic [width-1:0] one_q   = width'(1);

    logic             tick;
    logic [width:0]   q_ext;
    logic [width:0]   q_inc;
    logic [width-1:0] step_q;
    logic             step_evt;
    logic [width-1:0] ld_q;

    // tick marks an edge on which the counter actually steps
    generate
        if (prescale > 1) begin : g_pre
            localparam int pw = $clog2(prescale);
            localparam logic [pw-1:0] pre_last = pw'(prescale-1);
            logic [pw-1:0] pre;

            always_ff @(posedge clk) begin
                if (!reset || load) begin
                    pre <= '0;
                end else if (en) begin
                    pre <= (pre == pre_last) ? '0 : pre + pw'(1);
                end
            end

            assign tick = en && !load && (pre == pre_last);
        end else begin : g_nopre
            assign tick = en && !load;
        end
    endgenerate

    // Comparisons use one extra bit so q never leaves 0..max_count
    always_comb begin
        q_ext    = {1'b0, q};
        q_inc    = q_ext + one_ext;
        step_q   = q;
        step_evt = 1'b0;
        ld_q     = ({1'b0, d} > max_ext) ? max_q : d;
        if (up) begin
            if (q_ext < max_ext) begin
                step_q   = q_inc[width-1:0];
                step_evt = saturate && (q_inc == max_ext);
            end else if (!saturate) begin
                step_q   = '0;
                step_evt = 1'b1;
            end
        end else begin
            if (q != '0) begin
                step_q   = q - one_q;
                step_evt = saturate && (q == one_q);
            end else if (!saturate) begin
                step_q   = max_q;
                step_evt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q   <= rst_q;
            evt <= 1'b0;
        end else if (load) begin
            q   <= ld_q;
            evt <= 1'b0;
        end else if (tick) begin
            q   <= step_q;
            evt <= step_evt;
        end else begin
            evt <= 1'b0;
        end
    end

    assign tc = up ? (q == max_q) : (q == '0);

endmodule

// File: tb/tb_contador_updown_modulo.sv
// Directed bench for contador_updown_modulo: four parameterisations share the
// same stimulus; each test task checks the instance relevant to it.
module tb_contador_updown_modulo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] d = '0;

    logic [3:0] qa, qb, qc, qd;
    logic       tca, tcb, tcc, tcd;
    logic       evta, evtb, evtc, evtd;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // a: defaults, b: modulo 10 wrap, c: modulo 10 saturate, d: prescale 3
    contador_updown_modulo u_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d),
        .q(qa), .tc(tca), .evt(evta));
    contador_updown_modulo #(.max_count(9)) u_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d),
        .q(qb), .tc(tcb), .evt(evtb));
    contador_updown_modulo #(.max_count(9), .saturate(1'b1)) u_c (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d),
        .q(qc), .tc(tcc), .evt(evtc));
    contador_updown_modulo #(.prescale(3)) u_d (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d),
        .q(qd), .tc(tcd), .evt(evtd));

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic dir);
        reset = 1'b0; load = 1'b0; en = 1'b0; up = dir; d = '0;
        step_clk();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(1'b0);
        vectors++;
        if (qa !== 4'd15 || evta !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_a q=%0d evt=%0d want q=15 evt=0", qa, evta);
        end
        vectors++;
        if (qb !== 4'd9 || qc !== 4'd9 || qd !== 4'd15) begin
            miscompares++;
            $display("FAIL reset_bcd q=%0d/%0d/%0d want 9/9/15", qb, qc, qd);
        end
    endtask

    task automatic test_default_down();
        logic [3:0] exp;
        apply_reset(1'b0);
        en = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step_clk();
            exp = 4'(15 - k);
            vectors++;
            if (qa !== exp || evta !== 1'b0) begin
                miscompares++;
                $display("FAIL down_seq step %0d q=%0d evt=%0d want q=%0d evt=0", k, qa, evta, exp);
            end
        end
        vectors++;
        if (tca !== 1'b1) begin
            miscompares++;
            $display("FAIL down_tc_at_0 tc=%0d want 1", tca);
        end
        step_clk();
        vectors++;
        if (qa !== 4'd15 || evta !== 1'b1) begin
            miscompares++;
            $display("FAIL down_wrap q=%0d evt=%0d want q=15 evt=1", qa, evta);
        end
        step_clk();
        vectors++;
        if (qa !== 4'd14 || evta !== 1'b0) begin
            miscompares++;
            $display("FAIL down_after_wrap q=%0d evt=%0d want q=14 evt=0", qa, evta);
        end
    endtask

    task automatic test_up_wrap();
        apply_reset(1'b1);
        vectors++;
        if (qb !== 4'd9 || tcb !== 1'b1) begin
            miscompares++;
            $display("FAIL upwrap_start q=%0d tc=%0d want q=9 tc=1", qb, tcb);
        end
        en = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            step_clk();
            vectors++;
            if (qb !== 4'd0 || evtb !== 1'b1 || tcb !== 1'b0) begin
                miscompares++;
                $display("FAIL upwrap_wrap pass %0d q=%0d evt=%0d tc=%0d want q=0 evt=1 tc=0", pass, qb, evtb, tcb);
            end
            for (int i = 1; i <= 9; i++) begin
                step_clk();
                vectors++;
                if (qb !== 4'(i) || evtb !== 1'b0 || tcb !== (i == 9)) begin
                    miscompares++;
                    $display("FAIL upwrap_seq q=%0d evt=%0d tc=%0d want q=%0d evt=0 tc=%0d", qb, evtb, tcb, i, (i == 9));
                end
            end
        end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_q [5] = '{4'd7, 4'd8, 4'd9, 4'd9, 4'd9};
        logic       exp_e [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        apply_reset(1'b1);
        en = 1'b1; load = 1'b1; d = 4'd7;
        step_clk();
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step_clk();
            vectors++;
            if (qc !== exp_q[i] || evtc !== exp_e[i]) begin
                miscompares++;
                $display("FAIL sat_up idx %0d q=%0d evt=%0d want q=%0d evt=%0d", i, qc, evtc, exp_q[i], exp_e[i]);
            end
        end
        up = 1'b0;
        step_clk();
        vectors++;
        if (qc !== 4'd8 || evtc !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_turn q=%0d evt=%0d want q=8 evt=0", qc, evtc);
        end
    endtask

    task automatic test_prescale();
        // edges 1..11 after release; en low on edges 8 and 9
        logic [3:0] exp_q [11] = '{15, 15, 14, 14, 14, 13, 13, 13, 13, 13, 12};
        apply_reset(1'b0);
        for (int e = 1; e <= 11; e++) begin
            en = !(e == 8 || e == 9);
            step_clk();
            vectors++;
            if (qd !== exp_q[e-1]) begin
                miscompares++;
                $display("FAIL prescale edge %0d q=%0d want %0d", e, qd, exp_q[e-1]);
            end
        end
    endtask

    task automatic test_load();
        apply_reset(1'b0);
        load = 1'b1; d = 4'd15;
        step_clk();
        vectors++;
        if (qb !== 4'd9) begin
            miscompares++;
            $display("FAIL load_clamp q=%0d want 9", qb);
        end
        load = 1'b0; en = 1'b1;
        step_clk();
        load = 1'b1; d = 4'd4;
        step_clk();
        load = 1'b0;
        vectors++;
        if (qb !== 4'd4 || qd !== 4'd4) begin
            miscompares++;
            $display("FAIL load_d4 q=%0d/%0d want 4/4", qb, qd);
        end
        // one enabled edge happened before the load; cleared prescaler needs 3 more
        for (int e = 1; e <= 3; e++) begin
            step_clk();
            vectors++;
            if (qd !== ((e == 3) ? 4'd3 : 4'd4)) begin
                miscompares++;
                $display("FAIL load_pre_clear edge %0d q=%0d want %0d", e, qd, (e == 3) ? 3 : 4);
            end
        end
    endtask

    task automatic test_priority();
        apply_reset(1'b0);
        reset = 1'b0; load = 1'b1; d = 4'd3;
        step_clk();
        vectors++;
        if (qb !== 4'd9 || qa !== 4'd15) begin
            miscompares++;
            $display("FAIL prio_reset_load q=%0d/%0d want 9/15", qb, qa);
        end
        reset = 1'b1; load = 1'b1; d = 4'd0;
        step_clk();
        load = 1'b0; en = 1'b1; up = 1'b0;
        reset = 1'b0;
        step_clk();
        vectors++;
        if (qa !== 4'd15 || evta !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_reset_midcount q=%0d evt=%0d want q=15 evt=0", qa, evta);
        end
        reset = 1'b1;
        step_clk();
        vectors++;
        if (qa !== 4'd14 || evta !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_after_reset q=%0d evt=%0d want q=14 evt=0", qa, evta);
        end
    endtask

    initial begin
        test_reset();
        test_default_down();
        test_up_wrap();
        test_saturate();
        test_prescale();
        test_load();
        test_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
